approx_seq_divider: RTL

- Sequential restoring divider; the inverse-direction companion to the team's 4x4 approximate multiplier datapath.
- Takes an 8-bit dividend (the multiplier product width) and a 4-bit divisor (the operand width). Returns quotient and remainder one bit per cycle.
- Used to recover operands from products and to characterise product error.
- Sits behind a valid/ready handshake on both input and output.

---
 rtl/approx_seq_divider_if.sv | 26 ++
 rtl/approx_seq_divider.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/approx_seq_divider_if.sv
// approx_seq_divider_if: operand/result handshake bundle for approx_seq_divider.
// The divider side uses the slave modport; the producer/consumer side uses master.
interface approx_seq_divider_if #(
    parameter int DW = 8,
    parameter int VW = 4
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/approx_seq_divider.sv
// approx_seq_divider: sequential restoring divider, one quotient bit per clock,
// MSB first, behind valid/ready handshakes on operands and result.
// Optional macro APPROX_DIV_TRUNC_EN: only the top DW-TRUNC_BITS quotient bits
// are computed, the low quotient bits and the remainder are returned as zero.
module approx_seq_divider #(
    parameter int DW         = 8,
    parameter int VW         = 4,
    parameter int TRUNC_BITS = 2
) (
    input logic                  clk,
    input logic                  rst_n,
    approx_seq_divider_if.slave  bus
);

`ifdef APPROX_DIV_TRUNC_EN
    localparam bit TRUNC_EN = 1'b1;
`else
    localparam bit TRUNC_EN = 1'b0;
`endif

    // Number of CALC edges per operation; the truncated build stops early.
    localparam int ITERS = TRUNC_EN ? (DW - TRUNC_BITS) : DW;
    localparam int CW    = $clog2(DW + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(ITERS - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] shiftD_q, shiftD_d;
    logic [VW-1:0] divisor_q, divisor_d;
    logic [VW:0]   partRem_q, partRem_d;
    logic [CW-1:0] bitCnt_q, bitCnt_d;
    logic [DW-1:0] quotient_q, quotient_d;
    logic [VW-1:0] remainder_q, remainder_d;
    logic          divByZero_q, divByZero_d;

    logic [VW:0]   remShift;
    logic [VW:0]   remSub;
    logic [VW:0]   remNext;
    logic          qBit;
    logic [DW-1:0] shiftNext;

    // One restoring step: bring in the next dividend bit, subtract if it fits.
    always_comb begin
        remShift  = {partRem_q[VW-1:0], shiftD_q[DW-1]};
        remSub    = remShift - {1'b0, divisor_q};
        qBit      = (remShift >= {1'b0, divisor_q});
        remNext   = qBit ? remSub : remShift;
        shiftNext = {shiftD_q[DW-2:0], qBit};
    end

    // Next-state and next-register decode for the IDLE/CALC/DONE controller.
    always_comb begin
        state_d     = state_q;
        shiftD_d    = shiftD_q;
        divisor_d   = divisor_q;
        partRem_d   = partRem_q;
        bitCnt_d    = bitCnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        divByZero_d = divByZero_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    shiftD_d  = bus.dividend;
                    divisor_d = bus.divisor;
                    partRem_d = '0;
                    bitCnt_d  = '0;
                    if (bus.divisor != '0) begin
                        state_d = CALC;
                    end else begin
                        quotient_d  = '1;
                        remainder_d = '0;
                        divByZero_d = 1'b1;
                        state_d     = DONE;
                    end
                end
            end
            CALC: begin
                shiftD_d  = shiftNext;
                partRem_d = remNext;
                bitCnt_d  = bitCnt_q + 1'b1;
                if (bitCnt_q == LAST_CNT) begin
                    divByZero_d = 1'b0;
                    state_d     = DONE;
`ifdef APPROX_DIV_TRUNC_EN
                    quotient_d  = shiftNext << TRUNC_BITS;
                    remainder_d = '0;
`else
                    quotient_d  = shiftNext;
                    remainder_d = remNext[VW-1:0];
`endif
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shiftD_q    <= '0;
            divisor_q   <= '0;
            partRem_q   <= '0;
            bitCnt_q    <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            divByZero_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shiftD_q    <= shiftD_d;
            divisor_q   <= divisor_d;
            partRem_q   <= partRem_d;
            bitCnt_q    <= bitCnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            divByZero_q <= divByZero_d;
        end
    end

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.out_valid   = (state_q == DONE);
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = divByZero_q;

endmodule
